gauss_kernel_gen: RTL and testbench

//   Runtime-configurable 2D Gaussian kernel generator. Successor to the fixed-size kernel builder.

---
 rtl/gauss_kernel_pkg.sv | 27 ++
 rtl/gauss_kernel_gen_divider.sv | 58 +++++
 rtl/gauss_kernel_gen.sv | 189 ++++++++++++++++++
 tb/tb_gauss_kernel_gen.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_kernel_pkg.sv
// Shared types, widths and the Gaussian sample LUT for gauss_kernel_gen.
package gauss_kernel_pkg;

   localparam int unsigned DEF_MAX_KSIZE = 7;
   localparam int unsigned DEF_COEF_W    = 8;
   localparam int unsigned DEF_SIGMA_W   = 3;

   localparam int unsigned G_W   = 8;
   localparam int unsigned S_W   = 11;
   localparam int unsigned T_W   = 22;
   localparam int unsigned DVD_W = DEF_COEF_W + 16;

   typedef enum logic [2:0] {IDLE, CHECK, LOAD, SUM, DIV, FIN} state_t;

   // round(255*exp(-d^2/(2*sigma^2))), indexed [d][sigma]; sigma 0 is never used
   localparam logic [G_W-1:0] G_LUT [4][8] = '{
      '{8'd0, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255},
      '{8'd0, 8'd155, 8'd225, 8'd241, 8'd247, 8'd250, 8'd251, 8'd252},
      '{8'd0, 8'd35,  8'd155, 8'd204, 8'd225, 8'd235, 8'd241, 8'd245},
      '{8'd0, 8'd3,   8'd83,  8'd155, 8'd192, 8'd213, 8'd225, 8'd233}
   };

   function automatic logic [G_W-1:0] g_lut(input logic [1:0] d, input logic [2:0] s);
      return G_LUT[d][s];
   endfunction

endpackage

// File: rtl/gauss_kernel_gen_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses with the final quotient.
module gauss_divider
   import gauss_kernel_pkg::*;
#(
   parameter int unsigned NUM_W = DVD_W,
   parameter int unsigned DEN_W = T_W
) (
   input  logic             clk,
   input  logic             n_rst,
   input  logic             start,
   input  logic [NUM_W-1:0] dividend,
   input  logic [DEN_W-1:0] divisor,
   output logic [NUM_W-1:0] quotient,
   output logic             done
);
   localparam int unsigned CNT_W = $clog2(NUM_W + 1);

   logic [DEN_W-1:0] rem;
   logic [DEN_W-1:0] den_q;
   logic [CNT_W-1:0] cnt;
   logic [DEN_W:0]   shifted_c;
   logic [DEN_W:0]   trial_c;

   // remainder < divisor, so the trial difference never needs more than DEN_W+1 bits
   always_comb begin
      shifted_c = {rem, quotient[NUM_W-1]};
      trial_c   = shifted_c - {1'b0, den_q};
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         rem      <= '0;
         den_q    <= '0;
         quotient <= '0;
         cnt      <= '0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            quotient <= dividend;
            den_q    <= divisor;
            rem      <= '0;
            cnt      <= CNT_W'(NUM_W);
         end else if (cnt != '0) begin
            cnt  <= cnt - CNT_W'(1);
            done <= (cnt == CNT_W'(1));
            if (!trial_c[DEN_W]) begin
               rem      <= trial_c[DEN_W-1:0];
               quotient <= {quotient[NUM_W-2:0], 1'b1};
            end else begin
               rem      <= shifted_c[DEN_W-1:0];
               quotient <= {quotient[NUM_W-2:0], 1'b0};
            end
         end
      end
   end

endmodule

// File: rtl/gauss_kernel_gen.sv
// Runtime-configurable normalised 2D Gaussian kernel generator (odd N, integer sigma).
// Define SEPARABLE_OUT_EN to also produce the normalised 1D kernel on kernel_1d.
module gauss_kernel_gen
   import gauss_kernel_pkg::*;
#(
   parameter int unsigned MAX_KSIZE = DEF_MAX_KSIZE,
   parameter int unsigned COEF_W    = DEF_COEF_W,
   parameter int unsigned SIGMA_W   = DEF_SIGMA_W
) (
   input  logic                                            clk,
   input  logic                                            n_rst,
   input  logic                                            start,
   input  logic [SIGMA_W-1:0]                              sigma,
   input  logic [$clog2(MAX_KSIZE+1)-1:0]                  kernel_size,
   output logic [MAX_KSIZE-1:0][MAX_KSIZE-1:0][COEF_W-1:0] kernel,
   output logic                                            busy,
`ifdef SEPARABLE_OUT_EN
   output logic [MAX_KSIZE-1:0][COEF_W-1:0]                kernel_1d,
`endif
   output logic                                            done,
   output logic                                            err
);
   localparam int unsigned KS_W  = $clog2(MAX_KSIZE + 1);
   localparam int unsigned R_MAX = (MAX_KSIZE - 1) / 2;
   localparam int unsigned IDX_W = (R_MAX > 1) ? $clog2(R_MAX + 1) : 1;
   localparam int unsigned P_W   = 2 * G_W;
`ifdef SEPARABLE_OUT_EN
   localparam bit SEP = 1'b1;
`else
   localparam bit SEP = 1'b0;
`endif

   state_t                       state, state_nx;
   logic [SIGMA_W-1:0]           sigma_q;
   logic [KS_W-1:0]              n_q;
   logic [IDX_W-1:0]             r_q, ld_cnt, di, dj;
   logic [R_MAX:0][G_W-1:0]      g_q;
   logic [S_W-1:0]               s_q, s_c;
   logic [T_W-1:0]               t_q, divisor_c;
   logic [DVD_W-1:0]             dividend_c, div_q;
   logic [P_W-1:0]               prod_c;
   logic [COEF_W-1:0]            coef_c;
   logic [KS_W-1:0]              i_lo_c, i_hi_c, j_lo_c, j_hi_c;
   logic                         issue_q, pass1d_q, div_done;
   logic                         accept_c, bad_c, div_start_c, wr_c, last_c;

   // S = g[0] + 2*sum(g[1..R]); entries beyond R are held at zero
   always_comb begin
      s_c = S_W'(g_q[0]);
      for (int d = 1; d <= int'(R_MAX); d++) s_c = s_c + (S_W'(g_q[IDX_W'(d)]) << 1);
   end

   // Divider operands, saturation and the four mirrored write positions
   always_comb begin
      prod_c     = P_W'(g_q[di]) * P_W'(g_q[dj]);
      dividend_c = pass1d_q ? (DVD_W'(g_q[di]) << COEF_W) : (DVD_W'(prod_c) << COEF_W);
      divisor_c  = pass1d_q ? T_W'(s_q) : t_q;
      coef_c     = (|div_q[DVD_W-1:COEF_W]) ? '1 : div_q[COEF_W-1:0];
      i_lo_c     = KS_W'(r_q) - KS_W'(di);
      i_hi_c     = KS_W'(r_q) + KS_W'(di);
      j_lo_c     = KS_W'(r_q) - KS_W'(dj);
      j_hi_c     = KS_W'(r_q) + KS_W'(dj);
   end

   always_ff @(posedge clk) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      accept_c    = 1'b0;
      div_start_c = 1'b0;
      wr_c        = 1'b0;
      bad_c       = !n_q[0] || (n_q < KS_W'(3)) ||
                    ({1'b0, n_q} > (KS_W+1)'(MAX_KSIZE)) || (sigma_q == '0);
      last_c      = !pass1d_q && (di == r_q) && (dj == r_q);
      case (state)
         IDLE:  if (start && !done) begin
                   accept_c = 1'b1;
                   state_nx = CHECK;
                end
         CHECK: state_nx = bad_c ? FIN : LOAD;
         LOAD:  if (ld_cnt == r_q) state_nx = SUM;
         SUM:   state_nx = DIV;
         DIV:   if (issue_q) div_start_c = 1'b1;
                else if (div_done) begin
                   wr_c = 1'b1;
                   if (last_c) state_nx = FIN;
                end
         FIN:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         kernel   <= '0;
`ifdef SEPARABLE_OUT_EN
         kernel_1d <= '0;
`endif
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         sigma_q  <= '0;
         n_q      <= '0;
         r_q      <= '0;
         g_q      <= '0;
         ld_cnt   <= '0;
         s_q      <= '0;
         t_q      <= '0;
         di       <= '0;
         dj       <= '0;
         issue_q  <= 1'b0;
         pass1d_q <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept_c) begin
            sigma_q  <= sigma;
            n_q      <= kernel_size;
            r_q      <= IDX_W'((kernel_size - KS_W'(1)) >> 1);
            busy     <= 1'b1;
            err      <= 1'b0;
            kernel   <= '0;
`ifdef SEPARABLE_OUT_EN
            kernel_1d <= '0;
`endif
            g_q      <= '0;
            ld_cnt   <= '0;
            di       <= '0;
            dj       <= '0;
            issue_q  <= 1'b1;
            pass1d_q <= SEP;
         end
         if (state == CHECK && bad_c) err <= 1'b1;
         if (state == LOAD) begin
            g_q[ld_cnt] <= g_lut(2'(ld_cnt), 3'(sigma_q));
            ld_cnt      <= ld_cnt + IDX_W'(1);
         end
         if (state == SUM) begin
            s_q <= s_c;
            t_q <= T_W'(s_c) * T_W'(s_c);
         end
         if (div_start_c) issue_q <= 1'b0;
         // Write cycle: mirror the quotient, then step 1D index or 2D quadrant (row-major)
         if (wr_c) begin
            issue_q <= 1'b1;
            if (pass1d_q) begin
`ifdef SEPARABLE_OUT_EN
               kernel_1d[i_lo_c] <= coef_c;
               kernel_1d[i_hi_c] <= coef_c;
`endif
               if (di == r_q) begin
                  pass1d_q <= 1'b0;
                  di       <= '0;
               end else begin
                  di <= di + IDX_W'(1);
               end
            end else begin
               kernel[i_lo_c][j_lo_c] <= coef_c;
               kernel[i_lo_c][j_hi_c] <= coef_c;
               kernel[i_hi_c][j_lo_c] <= coef_c;
               kernel[i_hi_c][j_hi_c] <= coef_c;
               if (dj == r_q) begin
                  dj <= '0;
                  di <= di + IDX_W'(1);
               end else begin
                  dj <= dj + IDX_W'(1);
               end
            end
         end
         if (state == FIN) begin
            busy <= 1'b0;
            done <= 1'b1;
         end
      end
   end

   gauss_divider #(.NUM_W(DVD_W), .DEN_W(T_W)) u_div (
      .clk      (clk),
      .n_rst    (n_rst),
      .start    (div_start_c),
      .dividend (dividend_c),
      .divisor  (divisor_c),
      .quotient (div_q),
      .done     (div_done)
   );

endmodule

// File: tb/tb_gauss_kernel_gen.sv
// Self-checking bench for gauss_kernel_gen: exp()-based reference model plus literal pins.
module tb_gauss_kernel_gen;

   logic                 clk = 1'b0;
   logic                 n_rst;
   logic                 start;
   logic [2:0]           sigma;
   logic [2:0]           kernel_size;
   logic [6:0][6:0][7:0] kernel;
   logic                 busy, done, err;
`ifdef SEPARABLE_OUT_EN
   logic [6:0][7:0]      kernel_1d;
`endif

   int  n_cmp = 0;
   int  n_err = 0;
   bit  chk_en = 1'b0;
   int  mk [7][7];
   int  m1 [7];
   bit  m_bad;
   int  m_lat;

   gauss_kernel_gen dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .sigma       (sigma),
      .kernel_size (kernel_size),
      .kernel      (kernel),
      .busy        (busy),
`ifdef SEPARABLE_OUT_EN
      .kernel_1d   (kernel_1d),
`endif
      .done        (done),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int got, input int want);
      n_cmp++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   // Reference: kernel built directly from the Gaussian definition with real arithmetic
   task automatic set_model(input int n, input int s);
      int     g [4];
      int     r, ssum, di, dj;
      longint t, k;
      m_bad = (n % 2 == 0) || (n < 3) || (n > 7) || (s == 0);
      for (int i = 0; i < 7; i++) begin
         m1[i] = 0;
         for (int j = 0; j < 7; j++) mk[i][j] = 0;
      end
      if (m_bad) begin
         m_lat = 2;
         return;
      end
      r = (n - 1) / 2;
      for (int d = 0; d < 4; d++) g[d] = 0;
      for (int d = 0; d <= r; d++)
         g[d] = $rtoi(255.0 * $exp(-real'(d * d) / (2.0 * real'(s * s))) + 0.5);
      ssum = g[0];
      for (int d = 1; d <= r; d++) ssum += 2 * g[d];
      t = longint'(ssum) * longint'(ssum);
      for (int i = 0; i < n; i++) begin
         di = (i > r) ? i - r : r - i;
         k = (longint'(g[di]) * 256) / longint'(ssum);
         m1[i] = (k > 255) ? 255 : int'(k);
         for (int j = 0; j < n; j++) begin
            dj = (j > r) ? j - r : r - j;
            k = (longint'(g[di]) * longint'(g[dj]) * 256) / t;
            mk[i][j] = (k > 255) ? 255 : int'(k);
         end
      end
      m_lat = 3 + (r + 1) + (r + 1) * (r + 1) * 26;
`ifdef SEPARABLE_OUT_EN
      m_lat += (r + 1) * 26;
`endif
   endtask

   // Every cycle between done and the next start: outputs must match the model
   always @(negedge clk) begin : cmp_proc
      int nbad, fi, fj;
      if (chk_en) begin
         nbad = 0; fi = 0; fj = 0;
         for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
               if (int'(kernel[3'(i)][3'(j)]) != mk[i][j]) begin
                  if (nbad == 0) begin fi = i; fj = j; end
                  nbad++;
               end
         n_cmp++;
         if (nbad != 0) begin
            n_err++;
            $display("FAIL kernel[%0d][%0d]: got %0d expected %0d (%0d elements differ)",
                     fi, fj, kernel[3'(fi)][3'(fj)], mk[fi][fj], nbad);
         end
`ifdef SEPARABLE_OUT_EN
         for (int i = 0; i < 7; i++) check("kernel_1d", int'(kernel_1d[3'(i)]), m1[i]);
`endif
         check("err_level", int'(err), int'(m_bad));
         check("busy_idle", int'(busy), 0);
      end
   end

   task automatic run(input int n, input int s, input bit disturb);
      int cyc;
      bit seen;
      set_model(n % 8, s % 8);
      chk_en      = 1'b0;
      start       = 1'b1;
      sigma       = 3'(s);
      kernel_size = 3'(n);
      @(posedge clk); #1;
      start       = 1'b0;
      sigma       = 3'($urandom);
      kernel_size = 3'($urandom);
      check("busy_after_accept", int'(busy), 1);
      check("err_cleared_on_accept", int'(err), 0);
      cyc  = 0;
      seen = 1'b0;
      while (!seen && cyc < 2000) begin
         @(posedge clk); #1;
         cyc++;
         if (done) seen = 1'b1;
         else if (disturb && (cyc % 37 == 5) && (cyc < m_lat - 3)) begin
            start       = 1'b1;
            sigma       = 3'($urandom);
            kernel_size = 3'($urandom);
         end else start = 1'b0;
         if (!seen) check("busy_during_build", int'(busy), 1);
      end
      start = 1'b0;
      check("done_seen", int'(seen), 1);
      check("latency", cyc, m_lat);
      check("busy_at_done", int'(busy), 0);
      chk_en = 1'b1;
      @(posedge clk); #1;
      check("done_one_cycle", int'(done), 0);
   endtask

   initial begin : stim
      int lit [3][3];
      int sum, viol, mx;
      lit = '{'{19, 31, 19}, '{31, 52, 31}, '{19, 31, 19}};
      n_rst = 1'b0; start = 1'b0; sigma = '0; kernel_size = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_kernel_zero", int'(kernel != '0), 0);
      check("reset_busy", int'(busy), 0);
      check("reset_done", int'(done), 0);
      check("reset_err", int'(err), 0);
      n_rst = 1'b1;
      @(posedge clk); #1;

      // N=3 sigma=1, pinned to hand-computed values
      run(3, 1, 1'b0);
      sum = 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            check("t1_literal", int'(kernel[3'(i)][3'(j)]), lit[i][j]);
            sum += int'(kernel[3'(i)][3'(j)]);
         end
      check("t1_sum", sum, 252);
`ifdef SEPARABLE_OUT_EN
      check("t5_1d_0", int'(kernel_1d[0]), 70);
      check("t5_1d_1", int'(kernel_1d[1]), 115);
      check("t5_1d_2", int'(kernel_1d[2]), 70);
      check("t5_latency_literal", m_lat, 161);
`else
      check("t1_latency_literal", m_lat, 109);
`endif

      // Invalid requests
      run(4, 2, 1'b0);
      check("t2_err_n4", int'(err), 1);
      run(9, 2, 1'b0);
      check("t2_err_n9", int'(err), 1);
      run(3, 0, 1'b0);
      check("t2_err_s0", int'(err), 1);
      run(6, 5, 1'b0);

      // N=7 sigma=2 with start pulses while busy, then symmetry properties
      run(7, 2, 1'b1);
      viol = 0; mx = 0;
      for (int i = 0; i < 7; i++)
         for (int j = 0; j < 7; j++) begin
            if (kernel[3'(i)][3'(j)] != kernel[3'(j)][3'(i)]) viol++;
            if (kernel[3'(i)][3'(j)] != kernel[3'(6 - i)][3'(j)]) viol++;
            if (kernel[3'(i)][3'(j)] != kernel[3'(i)][3'(6 - j)]) viol++;
            if (int'(kernel[3'(i)][3'(j)]) > mx) mx = int'(kernel[3'(i)][3'(j)]);
         end
      check("t3_symmetry_violations", viol, 0);
      check("t3_centre_is_max", int'(kernel[3][3]), mx);

      // Reset in the middle of DIV, then a fresh build
      chk_en = 1'b0;
      start = 1'b1; sigma = 3'd5; kernel_size = 3'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (60) @(posedge clk);
      #1;
      n_rst = 1'b0;
      @(posedge clk); #1;
      check("t4_rst_kernel_zero", int'(kernel != '0), 0);
      check("t4_rst_busy", int'(busy), 0);
      check("t4_rst_done", int'(done), 0);
      check("t4_rst_err", int'(err), 0);
      n_rst = 1'b1;
      @(posedge clk); #1;
      run(3, 1, 1'b0);

      // Back-to-back builds
      run(5, 3, 1'b0);
      run(3, 1, 1'b0);
      check("t6_centre", int'(kernel[1][1]), 52);
      check("t6_err_clear", int'(err), 0);

      // Randomised requests
      for (int k = 0; k < 12; k++)
         run(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));

      chk_en = 1'b0;
      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
